gameover_curtain_ctrl: RTL and testbench
========================================

Name: gameover_curtain_ctrl

Overview:
Sequences the NES-style game-over curtain across the 20-row board. After a game-over request, it advances a row counter one row per FRAMES_PER_ROW video frames. The pixel path asks per row whether that row shows the game-over template, and the answer is fed to the block template ROM's gameover select. The block also freezes game logic during the animation and signals completion to the top-level game FSM.

Parameters:
BOARD_ROWS, 20, number of visible board rows; must be 1..31.
FRAMES_PER_ROW, 4, frame ticks between successive curtain rows; must be 1..255.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
frame_clk  in  1  vertical-sync-rate frame clock, sampled as data in the Clk domain.
gameover_req  in  1  level from game logic; starts the curtain when sampled high in IDLE.
restart  in  1  single-cycle pulse; returns to IDLE from DONE.
query_row  in  5  board row being rendered (0 = top).
query_gameover  out  1  combinational: that row currently shows the game-over template.
curtain_rows  out  5  number of rows covered, 0..BOARD_ROWS.
busy  out  1  high in FILL.
done  out  1  high in DONE.
freeze  out  1  high in FILL and DONE; game logic holds its state.

Behaviour:
- Clocking and reset: one clock (Clk); Reset is synchronous, active-high, and has priority over all other inputs.
- Reset values:
  - state=IDLE, curtain_rows=0, frame_cnt=0, frame_clk_q=0, frame_clk_qq=0.
  - busy=0, done=0, freeze=0.
- Frame tick:
  - frame_clk is registered twice (frame_clk_q, frame_clk_qq).
  - frame_tick = frame_clk_q & ~frame_clk_qq.
  - This gives one Clk-cycle pulse per rising frame_clk edge, 2 cycles after the edge is sampled.
- IDLE:
  - busy=0, done=0, freeze=0.
  - gameover_req=1 -> FILL on the next edge, with curtain_rows=0 and frame_cnt=0.
  - restart is ignored.
- FILL:
  - busy=1, freeze=1.
  - On frame_tick with frame_cnt<FRAMES_PER_ROW-1: frame_cnt+1.
  - On frame_tick with frame_cnt==FRAMES_PER_ROW-1: frame_cnt=0 and curtain_rows+1.
  - If the increment makes curtain_rows==BOARD_ROWS: -> DONE in the same edge.
  - gameover_req and restart are ignored.
  - Without frame_tick, the counters hold.
- DONE:
  - done=1, freeze=1, curtain_rows held at BOARD_ROWS.
  - restart=1 -> IDLE on the next edge, with curtain_rows=0 and frame_cnt=0.
  - If gameover_req is still high, the following cycle re-enters FILL (level semantics; top level must deassert).
- Total latency:
  - From gameover_req accepted to done=1: BOARD_ROWS*FRAMES_PER_ROW frame ticks.
  - done rises the cycle after the final tick.
- Query:
  - query_gameover = (query_row < curtain_rows).
  - Purely combinational, zero latency, so the pixel pipeline is unaffected.
  - query_row >= BOARD_ROWS -> 0.
  - In IDLE it is always 0, because curtain_rows=0.
- Widths:
  - frame_cnt is 8 bits; curtain_rows is 5 bits.
  - Comparisons are unsigned.
  - curtain_rows never exceeds BOARD_ROWS; there is no wrap.
- Outputs busy, done and freeze are decoded from registered state (no glitching).
- Reset mid-FILL: returns to IDLE within one cycle, with query_gameover=0 for every row.

Decomposition:
- Shared package tetris_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, DONE} curtain_state_t;
  - constants BOARD_ROWS=20 and BOARD_COLS=10.
- One natural sub-module: frame_tick_gen (two-flop sample plus rising-edge pulse), reused by other frame-rate animators.
- The FSM and counters stay in gameover_curtain_ctrl.

Test Plan:
- Reset and idle: Reset for 2 cycles, then toggle frame_clk 10 times with gameover_req=0 -> curtain_rows=0, busy=0, freeze=0, query_gameover=0 for rows 0..19.
- Full curtain (FRAMES_PER_ROW=2): assert gameover_req, then apply 39 frame_clk rising edges.
  - After 39 ticks: curtain_rows=19, busy=1.
  - After the 40th tick: done=1 the cycle after the tick, curtain_rows=20.
- Query boundary with curtain_rows=5: query_row 4 -> 1, query_row 5 -> 0, query_row 25 -> 0.
- Ignored inputs: pulse restart mid-FILL at curtain_rows=7, and hold gameover_req high throughout -> no state change, counting continues to 8 on schedule.
- Restart: in DONE, pulse restart with gameover_req=0 -> next cycle IDLE, curtain_rows=0, freeze=0, done=0.
- Reset mid-operation: assert Reset at curtain_rows=12 -> next cycle IDLE, curtain_rows=0, frame_cnt=0; a new gameover_req restarts from row 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry and curtain FSM state type for the Tetris video/game blocks.
package tetris_pkg;

    localparam int unsigned BOARD_ROWS = 20;
    localparam int unsigned BOARD_COLS = 10;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } curtain_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Samples the frame clock into the system clock domain and emits a one-cycle pulse per rising edge.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frame_clk_q;
    logic frame_clk_qq;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q  <= 1'b0;
            frame_clk_qq <= 1'b0;
        end else begin
            frame_clk_q  <= frame_clk;
            frame_clk_qq <= frame_clk_q;
        end
    end

    assign frame_tick = frame_clk_q & ~frame_clk_qq;

endmodule

// File: rtl/gameover_curtain_ctrl.sv
// Game-over curtain sequencer: covers one board row per FRAMES_PER_ROW frame ticks, freezes play,
// and answers per-row template-select queries for the pixel path.
module gameover_curtain_ctrl #(
    parameter int unsigned BOARD_ROWS     = tetris_pkg::BOARD_ROWS,
    parameter int unsigned FRAMES_PER_ROW = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       gameover_req,
    input  logic       restart,
    input  logic [4:0] query_row,
    output logic       query_gameover,
    output logic [4:0] curtain_rows,
    output logic       busy,
    output logic       done,
    output logic       freeze
);

    import tetris_pkg::curtain_state_t;
    import tetris_pkg::IDLE;
    import tetris_pkg::FILL;
    import tetris_pkg::DONE;

    localparam logic [4:0] RowsFull  = 5'(BOARD_ROWS);
    localparam logic [7:0] LastFrame = 8'(FRAMES_PER_ROW - 1);

    curtain_state_t state_q, state_d;
    logic [4:0]     rows_q, rows_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .frame_tick(frame_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            rows_q      <= 5'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gameover_req) begin
                    state_d     = FILL;
                    rows_d      = 5'd0;
                    frame_cnt_d = 8'd0;
                end
            end
            FILL: begin
                if (frame_tick) begin
                    if (frame_cnt_q == LastFrame) begin
                        frame_cnt_d = 8'd0;
                        rows_d      = rows_q + 5'd1;
                        // Final row lands and the FSM leaves FILL on the same edge.
                        if (rows_d == RowsFull) begin
                            state_d = DONE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            DONE: begin
                if (restart) begin
                    state_d     = IDLE;
                    rows_d      = 5'd0;
                    frame_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d     = IDLE;
                rows_d      = 5'd0;
                frame_cnt_d = 8'd0;
            end
        endcase
    end

    assign curtain_rows   = rows_q;
    assign query_gameover = (query_row < rows_q);
    assign busy           = (state_q == FILL);
    assign done           = (state_q == DONE);
    assign freeze         = (state_q == FILL) || (state_q == DONE);

endmodule

// File: tb/tb_gameover_curtain_ctrl.sv
// Randomized scoreboard bench for gameover_curtain_ctrl against a tick-count reference model.
module tb_gameover_curtain_ctrl;

    localparam int unsigned ROWS = 20;
    localparam int unsigned FPR  = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       gameover_req = 1'b0;
    logic       restart = 1'b0;
    logic [4:0] query_row = 5'd0;
    logic       query_gameover;
    logic [4:0] curtain_rows;
    logic       busy;
    logic       done;
    logic       freeze;

    gameover_curtain_ctrl #(
        .BOARD_ROWS    (ROWS),
        .FRAMES_PER_ROW(FPR)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .gameover_req  (gameover_req),
        .restart       (restart),
        .query_row     (query_row),
        .query_gameover(query_gameover),
        .curtain_rows  (curtain_rows),
        .busy          (busy),
        .done          (done),
        .freeze        (freeze)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int rows;
        bit busy;
        bit done;
        bit freeze;
        bit qgo;
        int qrow;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 idle, 1 filling, 2 finished; progress kept as total frame ticks.
    int m_phase = 0;
    int m_total = 0;
    bit m_h1 = 1'b0;   // frame_clk value seen at the previous edge
    bit m_h2 = 1'b0;   // frame_clk value seen two edges ago

    bit cur_gr = 1'b0;
    bit cur_fc = 1'b0;

    function automatic int model_rows();
        if (m_phase == 1) return m_total / FPR;
        if (m_phase == 2) return ROWS;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after the coming edge.
    task automatic step(input bit rst, input bit rs, input int qr);
        exp_t e;
        bit tick;
        @(negedge Clk);
        Reset        = rst;
        restart      = rs;
        gameover_req = cur_gr;
        frame_clk    = cur_fc;
        query_row    = 5'(qr);
        tick = m_h1 & ~m_h2;
        if (rst) begin
            m_phase = 0;
            m_total = 0;
            m_h1    = 1'b0;
            m_h2    = 1'b0;
        end else begin
            case (m_phase)
                0: if (cur_gr) begin m_phase = 1; m_total = 0; end
                1: if (tick) begin
                    m_total++;
                    if (m_total == ROWS * FPR) m_phase = 2;
                end
                default: if (rs) begin m_phase = 0; m_total = 0; end
            endcase
            m_h2 = m_h1;
            m_h1 = cur_fc;
        end
        e.rows   = model_rows();
        e.busy   = (m_phase == 1);
        e.done   = (m_phase == 2);
        e.freeze = (m_phase != 0);
        e.qrow   = qr;
        e.qgo    = (qr < e.rows);
        sb_q.push_back(e);
    endtask

    function automatic int pick_q();
        case ($urandom_range(0, 5))
            0: return 4;
            1: return 5;
            2: return 25;
            3: return 19;
            4: return 20;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    // One full frame_clk period with random low/high lengths; restart optionally sprinkled in.
    task automatic frame_edge(input bit allow_rs);
        int lo = int'($urandom_range(1, 3));
        int hi = int'($urandom_range(1, 3));
        cur_fc = 1'b0;
        repeat (lo) step(1'b0, allow_rs && ($urandom_range(0, 5) == 0), pick_q());
        cur_fc = 1'b1;
        repeat (hi) step(1'b0, allow_rs && ($urandom_range(0, 5) == 0), pick_q());
        cur_fc = 1'b0;
    endtask

    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("curtain_rows", 32'(curtain_rows), 32'(e.rows));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("freeze", 32'(freeze), 32'(e.freeze));
            chk($sformatf("query_gameover[row %0d]", e.qrow), 32'(query_gameover), 32'(e.qgo));
        end
    end

    initial begin
        int budget;
        // Reset, then idle frames with no request.
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) frame_edge(1'b1);
        for (int r = 0; r < 20; r++) step(1'b0, 1'b0, r);

        // Full curtain with request held high; restart pulses during FILL are ignored.
        cur_gr = 1'b1;
        step(1'b0, 1'b0, pick_q());
        for (int i = 0; i < 39; i++) frame_edge(1'b1);
        frame_edge(1'b0);
        repeat (3) step(1'b0, 1'b0, pick_q());

        // Restart out of DONE with the request dropped.
        cur_gr = 1'b0;
        repeat (2) step(1'b0, 1'b0, pick_q());
        step(1'b0, 1'b1, pick_q());
        repeat (3) step(1'b0, 1'b0, pick_q());

        // Reset mid-FILL at row 12, then a fresh curtain from row 0.
        cur_gr = 1'b1;
        step(1'b0, 1'b0, pick_q());
        budget = 0;
        while (!(m_phase == 1 && model_rows() == 12) && budget < 200) begin
            frame_edge(1'b0);
            budget++;
        end
        if (budget >= 200) begin
            errors++;
            $display("FAIL reach_row12: got budget %0d expected under 200", budget);
        end
        step(1'b1, 1'b0, 0);
        for (int r = 0; r < 20; r++) step(1'b0, 1'b0, r);
        cur_gr = 1'b0;
        budget = 0;
        while (m_phase != 2 && budget < 200) begin
            frame_edge(1'b0);
            budget++;
        end
        if (budget >= 200) begin
            errors++;
            $display("FAIL reach_done: got budget %0d expected under 200", budget);
        end
        step(1'b0, 1'b1, pick_q());

        // Random soak over all inputs.
        for (int i = 0; i < 3000; i++) begin
            cur_gr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) cur_fc = ~cur_fc;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), pick_q());
        end

        step(1'b0, 1'b0, 0);
        @(posedge Clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
